// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the producer (ID/EX issue) and consumer (EX ALU) sides
// of the ALU interface:
//   - 4-bit ALU opcode encoding
//   - RISC-V major opcodes recognised by the issue decoder
//   - funct7 values that select the base / alternate operation
// Also provides the funct3 -> ALU opcode mapping shared by OP and OP-IMM.
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU opcode encoding (consumed by the EX-stage ALU)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // RISC-V major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7 selectors
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 -> ALU opcode; alt selects SUB (000) or SRA (101).
    // Legality of alt for the other funct3 values is judged by the caller.
    function automatic logic [3:0] f3_to_alu_op(input logic [2:0] funct3,
                                                input logic       alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational decode of one RV32I instruction into ALU opcode and
// operands.
// Ports:
//   instr      in   32   instruction word
//   pc         in   W    PC of instr
//   rs1_data   in   W    forwarded rs1 value
//   rs2_data   in   W    forwarded rs2 value
//   alu_op     out  4    ALU opcode (ADD when illegal)
//   operand1   out  W    ALU operand 1
//   operand2   out  W    ALU operand 2
//   rd         out  5    destination register index
//   reg_write  out  1    writeback enable, already gated by rd!=0 and !illegal
//   illegal    out  1    instruction failed to decode
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic [31:0]              instr,
    input  logic [OPERAND_WIDTH-1:0] pc,
    input  logic [OPERAND_WIDTH-1:0] rs1_data,
    input  logic [OPERAND_WIDTH-1:0] rs2_data,
    output logic [3:0]               alu_op,
    output logic [OPERAND_WIDTH-1:0] operand1,
    output logic [OPERAND_WIDTH-1:0] operand2,
    output logic [4:0]               rd,
    output logic                     reg_write,
    output logic                     illegal
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_u_s;
    logic [31:0] shamt_s;
    logic [31:0] rs2_shamt_s;
    logic [3:0]  op_s;
    logic [31:0] op1_s;
    logic [31:0] op2_s;
    logic        we_s;
    logic        ill_s;

    assign opcode_s    = instr[6:0];
    assign funct3_s    = instr[14:12];
    assign funct7_s    = instr[31:25];
    assign imm_i_s     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u_s     = {instr[31:12], 12'b0};
    assign shamt_s     = {27'b0, instr[24:20]};
    // The ALU shifts by its whole operand, so register shift amounts must be
    // truncated to 5 bits here.
    assign rs2_shamt_s = {27'b0, rs2_data[4:0]};

    // Main decode: opcode, operand selects, write enable and legality
    always_comb begin
        op_s  = ALU_ADD;
        op1_s = rs1_data;
        op2_s = rs2_data;
        we_s  = 1'b0;
        ill_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                we_s = 1'b1;
                if (funct7_s == F7_ZERO) begin
                    op_s = f3_to_alu_op(funct3_s, 1'b0);
                end else if (funct7_s == F7_ALT) begin
                    if ((funct3_s == 3'b000) || (funct3_s == 3'b101)) begin
                        op_s = f3_to_alu_op(funct3_s, 1'b1);
                    end else begin
                        ill_s = 1'b1;
                    end
                end else begin
                    ill_s = 1'b1;
                end
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    op2_s = rs2_shamt_s;
                end else begin
                    op2_s = rs2_data;
                end
            end
            OPC_OP_IMM: begin
                we_s  = 1'b1;
                op2_s = imm_i_s;
                if (funct3_s == 3'b001) begin
                    op2_s = shamt_s;
                    op_s  = ALU_SLL;
                    if (funct7_s != F7_ZERO) begin
                        ill_s = 1'b1;
                    end else begin
                        ill_s = 1'b0;
                    end
                end else if (funct3_s == 3'b101) begin
                    op2_s = shamt_s;
                    if (funct7_s == F7_ZERO) begin
                        op_s = ALU_SRL;
                    end else if (funct7_s == F7_ALT) begin
                        op_s = ALU_SRA;
                    end else begin
                        ill_s = 1'b1;
                    end
                end else begin
                    // funct3 000 is ADDI; immediate bits never select SUB
                    op_s = f3_to_alu_op(funct3_s, 1'b0);
                end
            end
            OPC_LUI: begin
                we_s  = 1'b1;
                op1_s = 32'd0;
                op2_s = imm_u_s;
            end
            OPC_AUIPC: begin
                we_s  = 1'b1;
                op1_s = pc;
                op2_s = imm_u_s;
            end
            OPC_LOAD: begin
                we_s  = 1'b1;
                op2_s = imm_i_s;
            end
            OPC_STORE: begin
                op2_s = imm_s_s;
            end
            OPC_BRANCH: begin
                case (funct3_s)
                    3'b000, 3'b001: op_s  = ALU_SUB;
                    3'b100, 3'b101: op_s  = ALU_SLT;
                    3'b110, 3'b111: op_s  = ALU_SLTU;
                    default:        ill_s = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value pc+4
                we_s  = 1'b1;
                op1_s = pc;
                op2_s = 32'd4;
            end
            default: begin
                ill_s = 1'b1;
            end
        endcase
    end

    assign alu_op    = ill_s ? ALU_ADD : op_s;
    assign operand1  = op1_s;
    assign operand2  = op2_s;
    assign rd        = instr[11:7];
    assign reg_write = we_s & (instr[11:7] != 5'd0) & ~ill_s;
    assign illegal   = ill_s;

endmodule

// File: rtl/id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// id_ex_alu_issue
// ID/EX pipeline register on the producer side of the ALU interface. Decodes
// the ID-stage instruction (alu_op_decode) and registers opcode, operands and
// writeback control for the EX-stage ALU, one cycle latency.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (all outputs 0)
//   id_valid            ID holds a real instruction
//   id_instr/id_pc      instruction word and its PC
//   id_rs1_data/rs2     forwarded register operands
//   stall               hold every EX output
//   flush               kill the instruction entering EX (wins over stall)
//   ex_*                registered EX-stage outputs
// ---------------------------------------------------------------------------
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [31:0]              id_instr,
    input  logic [OPERAND_WIDTH-1:0] id_pc,
    input  logic [OPERAND_WIDTH-1:0] id_rs1_data,
    input  logic [OPERAND_WIDTH-1:0] id_rs2_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     ex_valid,
    output logic [3:0]               ex_alu_op,
    output logic [OPERAND_WIDTH-1:0] ex_operand1,
    output logic [OPERAND_WIDTH-1:0] ex_operand2,
    output logic [4:0]               ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_illegal
);

    logic [3:0]               dec_op_s;
    logic [OPERAND_WIDTH-1:0] dec_op1_s;
    logic [OPERAND_WIDTH-1:0] dec_op2_s;
    logic [4:0]               dec_rd_s;
    logic                     dec_we_s;
    logic                     dec_ill_s;

    logic                     valid_q, valid_d;
    logic [3:0]               op_q, op_d;
    logic [OPERAND_WIDTH-1:0] op1_q, op1_d;
    logic [OPERAND_WIDTH-1:0] op2_q, op2_d;
    logic [4:0]               rd_q, rd_d;
    logic                     we_q, we_d;
    logic                     ill_q, ill_d;

    alu_op_decode #(
        .OPERAND_WIDTH (OPERAND_WIDTH)
    ) u_dec (
        .instr     (id_instr),
        .pc        (id_pc),
        .rs1_data  (id_rs1_data),
        .rs2_data  (id_rs2_data),
        .alu_op    (dec_op_s),
        .operand1  (dec_op1_s),
        .operand2  (dec_op2_s),
        .rd        (dec_rd_s),
        .reg_write (dec_we_s),
        .illegal   (dec_ill_s)
    );

    // Next-state selection: flush > stall > load
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        we_d    = we_q;
        ill_d   = ill_q;
        if (flush) begin
            // Datapath fields load anyway; only the control bits are killed
            valid_d = 1'b0;
            op_d    = dec_op_s;
            op1_d   = dec_op1_s;
            op2_d   = dec_op2_s;
            rd_d    = dec_rd_s;
            we_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d = id_valid;
            op_d    = dec_op_s;
            op1_d   = dec_op1_s;
            op2_d   = dec_op2_s;
            rd_d    = dec_rd_s;
            we_d    = dec_we_s & id_valid;
            ill_d   = dec_ill_s & id_valid;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= 4'd0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_alu_op    = op_q;
    assign ex_operand1  = op1_q;
    assign ex_operand2  = op2_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = we_q;
    assign ex_illegal   = ill_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_id_ex_alu_issue
// Directed, self-checking bench for id_ex_alu_issue. Inputs change 1 time unit
// after the rising edge; outputs are examined 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_id_ex_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_operand1;
    logic [31:0] ex_operand2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    id_ex_alu_issue #(.OPERAND_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_alu_op    (ex_alu_op),
        .ex_operand1  (ex_operand1),
        .ex_operand2  (ex_operand2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_illegal   (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        id_instr    = instr;
        id_pc       = pc;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
    endtask

    task automatic test_reset();
        logic [77:0] all_s;
        rst_n = 1'b0; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        tick(); tick();
        all_s = {ex_valid, ex_alu_op, ex_operand1, ex_operand2, ex_rd, ex_reg_write, ex_illegal};
        checks++; if (all_s !== 78'd0) begin errors++; $display("FAIL reset_zero: got %h expected 0", all_s); end
        rst_n = 1'b1;
        #2;
        all_s = {ex_valid, ex_alu_op, ex_operand1, ex_operand2, ex_rd, ex_reg_write, ex_illegal};
        checks++; if (all_s !== 78'd0) begin errors++; $display("FAIL release_zero: got %h expected 0", all_s); end
        tick();
        checks++; if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL add_op: got %h expected 0", ex_alu_op); end
        checks++; if (ex_operand1 !== 32'd5) begin errors++; $display("FAIL add_op1: got %h expected 5", ex_operand1); end
        checks++; if (ex_operand2 !== 32'd7) begin errors++; $display("FAIL add_op2: got %h expected 7", ex_operand2); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d expected 3", ex_rd); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_we: got %b expected 1", ex_reg_write); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", ex_valid); end
        checks++; if (ex_illegal !== 1'b0) begin errors++; $display("FAIL add_ill: got %b expected 0", ex_illegal); end
    endtask

    task automatic test_sub_srai();
        drive(32'h402081B3, 32'h0, 32'd9, 32'd4);
        tick();
        checks++; if (ex_alu_op !== 4'b0001) begin errors++; $display("FAIL sub_op: got %h expected 1", ex_alu_op); end
        drive(32'h40335293, 32'h0, 32'h80000000, 32'hFFFFFFFF);
        tick();
        checks++; if (ex_alu_op !== 4'b0111) begin errors++; $display("FAIL srai_op: got %h expected 7", ex_alu_op); end
        checks++; if (ex_operand1 !== 32'h80000000) begin errors++; $display("FAIL srai_op1: got %h expected 80000000", ex_operand1); end
        checks++; if (ex_operand2 !== 32'd3) begin errors++; $display("FAIL srai_op2: got %h expected 3", ex_operand2); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL srai_rd: got %0d expected 5", ex_rd); end
        // SLLI with funct7=0100000 is not a legal encoding
        drive(32'h40331293, 32'h0, 32'd1, 32'd1);
        tick();
        checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL slli_alt_ill: got %b expected 1", ex_illegal); end
        checks++; if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL slli_alt_op: got %h expected 0", ex_alu_op); end
    endtask

    task automatic test_imm_shift();
        drive(32'h123453B7, 32'h0, 32'hDEADBEEF, 32'h0);
        tick();
        checks++; if (ex_operand1 !== 32'd0) begin errors++; $display("FAIL lui_op1: got %h expected 0", ex_operand1); end
        checks++; if (ex_operand2 !== 32'h12345000) begin errors++; $display("FAIL lui_op2: got %h expected 12345000", ex_operand2); end
        checks++; if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL lui_op: got %h expected 0", ex_alu_op); end
        checks++; if (ex_rd !== 5'd7) begin errors++; $display("FAIL lui_rd: got %0d expected 7", ex_rd); end
        drive(32'hFFF00093, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (ex_operand2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_op2: got %h expected ffffffff", ex_operand2); end
        drive(32'h002091B3, 32'h0, 32'd8, 32'h21);
        tick();
        checks++; if (ex_operand2 !== 32'd1) begin errors++; $display("FAIL sll_mask: got %h expected 1", ex_operand2); end
        checks++; if (ex_alu_op !== 4'b0101) begin errors++; $display("FAIL sll_op: got %h expected 5", ex_alu_op); end
    endtask

    task automatic test_write_suppress();
        drive(32'h00000033, 32'h0, 32'd1, 32'd2);
        tick();
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", ex_reg_write); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b expected 1", ex_valid); end
        drive(32'h0000007F, 32'h0, 32'd1, 32'd2);
        tick();
        checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL unk_ill: got %b expected 1", ex_illegal); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL unk_we: got %b expected 0", ex_reg_write); end
        drive(32'h802081B3, 32'h0, 32'd1, 32'd2);
        tick();
        checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL f7_ill: got %b expected 1", ex_illegal); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL f7_we: got %b expected 0", ex_reg_write); end
    endtask

    task automatic test_stall_flush();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h402081B3 + (i * 32'h80), 32'h40, 32'd100 + i, 32'd200 + i);
            tick();
            checks++;
            if ({ex_valid, ex_alu_op, ex_operand1, ex_operand2, ex_rd, ex_reg_write}
                !== {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got op=%h op1=%h op2=%h rd=%0d we=%b v=%b expected op=0 op1=5 op2=7 rd=3 we=1 v=1",
                         i, ex_alu_op, ex_operand1, ex_operand2, ex_rd, ex_reg_write, ex_valid);
            end
        end
        flush = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ex_valid); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_we: got %b expected 0", ex_reg_write); end
        flush = 1'b0; stall = 1'b0;
        id_valid = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL novalid_valid: got %b expected 0", ex_valid); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL novalid_we: got %b expected 0", ex_reg_write); end
        id_valid = 1'b1;
    endtask

    task automatic test_branch_jump();
        drive(32'h0020C463, 32'h0, 32'd1, 32'd2);
        tick();
        checks++; if (ex_alu_op !== 4'b1000) begin errors++; $display("FAIL blt_op: got %h expected 8", ex_alu_op); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL blt_we: got %b expected 0", ex_reg_write); end
        drive(32'h0020A463, 32'h0, 32'd1, 32'd2);
        tick();
        checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL br010_ill: got %b expected 1", ex_illegal); end
        drive(32'h008000EF, 32'h100, 32'd9, 32'd9);
        tick();
        checks++; if (ex_operand1 !== 32'h100) begin errors++; $display("FAIL jal_op1: got %h expected 100", ex_operand1); end
        checks++; if (ex_operand2 !== 32'd4) begin errors++; $display("FAIL jal_op2: got %h expected 4", ex_operand2); end
        checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL jal_rd: got %0d expected 1", ex_rd); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL jal_we: got %b expected 1", ex_reg_write); end
    endtask

    task automatic test_reset_mid_stall();
        logic [77:0] all_s;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        tick();
        stall = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        all_s = {ex_valid, ex_alu_op, ex_operand1, ex_operand2, ex_rd, ex_reg_write, ex_illegal};
        checks++; if (all_s !== 78'd0) begin errors++; $display("FAIL reset_mid_stall: got %h expected 0", all_s); end
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sub_srai();
        test_imm_shift();
        test_write_suppress();
        test_stall_flush();
        test_branch_jump();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
